// File: rtl/deca4_pkg.sv
// deca4_pkg: phase encodings shared by the deca4 sequencer and the datapath
// decoder.
//   STATE_W  - width of the phase register
//   ST_*     - raw phase encodings; the datapath decodes against these
//   phase_e  - named view of the same encodings for FSM code
package deca4_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_FETCH = 3'b000;
  localparam logic [STATE_W-1:0] ST_EXEC1 = 3'b001;
  localparam logic [STATE_W-1:0] ST_EXEC2 = 3'b010;
  localparam logic [STATE_W-1:0] ST_HALT  = 3'b100;

  typedef enum logic [STATE_W-1:0] {
    PH_FETCH = ST_FETCH,
    PH_EXEC1 = ST_EXEC1,
    PH_EXEC2 = ST_EXEC2,
    PH_HALT  = ST_HALT
  } phase_e;

endpackage

// File: rtl/deca4_wrap_counter.sv
// deca4_wrap_counter: free-running up counter that wraps silently.
//   clk   - clock, rising edge
//   rst   - synchronous active-high clear
//   inc   - add one this cycle
//   count - current value, modulo 2^W
module deca4_wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/deca4_sequencer.sv
// deca4_sequencer: instruction-cycle sequencer for the deca4 CPU.
//   clk, rst     - clock and synchronous active-high reset
//   mem_ack      - instruction word returned this cycle (looked at in FETCH only)
//   extra        - instruction needs EXEC2 (looked at in EXEC1 only)
//   halt_req     - halt at the next instruction boundary (retire cycle only)
//   run          - leave HALT
//   state        - raw phase register, also serves as the FSM debug view
//   fetch/exec1/exec2/halted - one-hot phase strobes for the datapath
//   mem_req      - fetch request to instruction memory
//   retire       - pulse on the cycle an instruction completes
//   instr_count  - retired instructions modulo 2^CNT_W
//
// Memory handshake: mem_req is held high for every FETCH cycle; a fetch
// completes on the first rising edge where mem_req and mem_ack are both high.
// mem_ack while mem_req is low is ignored, and mem_req never drops before the
// ack arrives.
module deca4_sequencer
  import deca4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_ack,
  input  logic               extra,
  input  logic               halt_req,
  input  logic               run,
  output logic [STATE_W-1:0] state,
  output logic               fetch,
  output logic               exec1,
  output logic               exec2,
  output logic               mem_req,
  output logic               halted,
  output logic               retire,
  output logic [CNT_W-1:0]   instr_count
);

  phase_e state_q;
  phase_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are a pure decode of state_q; retire additionally looks at extra
  // in EXEC1 so a single-execute instruction retires without a wasted cycle.
  // Unlisted encodings fall into the default arm: every strobe low and a
  // recovery hop to FETCH.
  always_comb begin
    state_d = PH_FETCH;
    fetch   = 1'b0;
    exec1   = 1'b0;
    exec2   = 1'b0;
    halted  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      PH_FETCH: begin
        fetch   = 1'b1;
        state_d = mem_ack ? PH_EXEC1 : PH_FETCH;
      end
      PH_EXEC1: begin
        exec1 = 1'b1;
        if (extra) begin
          state_d = PH_EXEC2;
        end else begin
          retire  = 1'b1;
          state_d = halt_req ? PH_HALT : PH_FETCH;
        end
      end
      PH_EXEC2: begin
        exec2   = 1'b1;
        retire  = 1'b1;
        state_d = halt_req ? PH_HALT : PH_FETCH;
      end
      PH_HALT: begin
        halted  = 1'b1;
        state_d = run ? PH_FETCH : PH_HALT;
      end
      default: begin
        state_d = PH_FETCH;
      end
    endcase
  end

  assign mem_req = fetch;
  assign state   = state_q;

  deca4_wrap_counter #(
    .W(CNT_W)
  ) u_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (instr_count)
  );

endmodule

// File: tb/tb_deca4_sequencer.sv
module tb_deca4_sequencer;
  import deca4_pkg::*;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             mem_ack;
  logic             extra;
  logic             halt_req;
  logic             run;
  logic [2:0]       state;
  logic             fetch;
  logic             exec1;
  logic             exec2;
  logic             mem_req;
  logic             halted;
  logic             retire;
  logic [CNT_W-1:0] instr_count;

  deca4_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ack     (mem_ack),
    .extra       (extra),
    .halt_req    (halt_req),
    .run         (run),
    .state       (state),
    .fetch       (fetch),
    .exec1       (exec1),
    .exec2       (exec2),
    .mem_req     (mem_req),
    .halted      (halted),
    .retire      (retire),
    .instr_count (instr_count)
  );

  // ---------------- reference model ----------------
  // Phases by name; the numeric encoding only appears in enc_of().
  typedef enum {M_FETCH, M_EXEC1, M_EXEC2, M_HALT, M_ILL} mph_e;
  mph_e m_ph;
  int   m_count;
  logic [2:0] m_ill_code;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [2:0] enc_of(input mph_e p, input logic [2:0] ill);
    case (p)
      M_FETCH: return 3'b000;
      M_EXEC1: return 3'b001;
      M_EXEC2: return 3'b010;
      M_HALT:  return 3'b100;
      default: return ill;
    endcase
  endfunction

  function automatic logic model_retire();
    return (m_ph == M_EXEC1 && !extra) || (m_ph == M_EXEC2);
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic ret;
    ret = model_retire();
    if (rst) begin
      m_ph    = M_FETCH;
      m_count = 0;
    end else begin
      case (m_ph)
        M_FETCH: m_ph = mem_ack ? M_EXEC1 : M_FETCH;
        M_EXEC1: m_ph = extra ? M_EXEC2 : (halt_req ? M_HALT : M_FETCH);
        M_EXEC2: m_ph = halt_req ? M_HALT : M_FETCH;
        M_HALT:  m_ph = run ? M_FETCH : M_HALT;
        default: m_ph = M_FETCH;
      endcase
      if (ret) m_count = (m_count + 1) % (1 << CNT_W);
    end
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},   {5'd0, state},                enc_of(m_ph, m_ill_code));
    check({tag, ".fetch"},   {7'd0, fetch},                {7'd0, m_ph == M_FETCH});
    check({tag, ".exec1"},   {7'd0, exec1},                {7'd0, m_ph == M_EXEC1});
    check({tag, ".exec2"},   {7'd0, exec2},                {7'd0, m_ph == M_EXEC2});
    check({tag, ".mem_req"}, {7'd0, mem_req},              {7'd0, m_ph == M_FETCH});
    check({tag, ".halted"},  {7'd0, halted},               {7'd0, m_ph == M_HALT});
    check({tag, ".retire"},  {7'd0, retire},               {7'd0, model_retire()});
    check({tag, ".count"},   {{(8-CNT_W){1'b0}}, instr_count}, m_count[7:0]);
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are checked 1 time unit later,
  // well before the next rising edge.
  task automatic cycle(input logic a, input logic e, input logic h,
                       input logic r, input logic rs, input string tag);
    @(negedge clk);
    mem_ack  = a;
    extra    = e;
    halt_req = h;
    run      = r;
    rst      = rs;
    #1;
    check_all(tag);
    model_step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_ill_code = 3'b111;
    rst = 1'b1; mem_ack = 1'b0; extra = 1'b0; halt_req = 1'b0; run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    m_ph    = M_FETCH;
    m_count = 0;

    // reset values, then back-to-back single-execute instructions
    cycle(0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, "b2b");
    cycle(0, 0, 0, 0, 0, "b2b_end");

    // slow memory, extra execute cycle; ack outside FETCH ignored
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, "wait");
    cycle(1, 1, 0, 0, 0, "ack");
    cycle(1, 1, 0, 0, 0, "exec1x");
    cycle(1, 1, 0, 0, 0, "exec2");
    cycle(0, 0, 0, 0, 0, "after_exec2");

    // halt_req only during FETCH has no effect
    cycle(0, 0, 1, 0, 0, "hreq_fetch");
    cycle(1, 0, 1, 0, 0, "hreq_fetch2");
    cycle(0, 1, 0, 0, 0, "exec1_nohalt");
    cycle(0, 1, 1, 0, 0, "exec2_halt");
    cycle(1, 0, 1, 0, 0, "in_halt");
    cycle(1, 0, 0, 0, 0, "in_halt2");
    cycle(0, 0, 0, 1, 0, "run");
    cycle(1, 0, 0, 0, 0, "after_run");
    cycle(0, 0, 1, 0, 0, "exec1_halt");
    cycle(0, 0, 1, 1, 0, "run_and_hreq");
    cycle(0, 0, 0, 0, 0, "resume");

    // counter wrap: many retires at 4 bits
    for (int i = 0; i < 40; i++) cycle(1, 0, 0, 0, 0, "wrap");

    // reset while EXEC2 would retire
    cycle(0, 0, 0, 0, 0, "pre_rst");
    while (m_ph != M_FETCH) cycle(0, 0, 0, 0, 0, "to_fetch");
    cycle(1, 1, 0, 0, 0, "rst_fetch");
    cycle(0, 1, 0, 0, 0, "rst_exec1");
    cycle(0, 0, 1, 0, 1, "rst_in_exec2");
    cycle(0, 0, 0, 0, 0, "after_rst");

    // illegal encoding recovery with a nonzero count
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, "pre_ill");
    @(negedge clk);
    mem_ack = 1'b1; extra = 1'b0; halt_req = 1'b1; run = 1'b1; rst = 1'b0;
    force dut.state_q = phase_e'(3'b111);
    m_ph = M_ILL;
    #1;
    check_all("illegal");
    release dut.state_q;
    model_step();
    cycle(0, 0, 0, 0, 0, "after_ill");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 39) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
